// File: rtl/rom_arb_pkg.sv
// Shared ROM geometry and the in-flight owner encoding for the program ROM arbiter.
package rom_arb_pkg;

  localparam int ROM_ADDR_W = 15;
  localparam int ROM_DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_AUX  = 2'd2
  } owner_e;

endpackage

// File: rtl/rom_arb_age_counter.sv
// Saturating up-counter with synchronous clear; tracks how long aux has been refused.
module rom_arb_age_counter #(
  parameter  int MAX = 4,
  localparam int W   = $clog2(MAX + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != W'(MAX))) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of the registered program ROM: CPU has priority,
// aux is forced through once it has been refused MAX_WAIT consecutive cycles.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W   = ROM_ADDR_W,
  parameter int DATA_W   = ROM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] aux_addr,
  output logic              aux_gnt,
  output logic              aux_rvalid,
  output logic [DATA_W-1:0] aux_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam int AGE_W = $clog2(MAX_WAIT + 1);

  logic [AGE_W-1:0]  aux_age;
  logic              aux_force;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] last_addr_q;
  logic [DATA_W-1:0] cpu_rdata_q, aux_rdata_q;

  rom_arb_age_counter #(.MAX(MAX_WAIT)) u_age (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (aux_req && !aux_gnt),
    .clr_i   (aux_gnt || !aux_req),
    .count_o (aux_age)
  );

  assign aux_force = (aux_age == AGE_W'(MAX_WAIT));

  always_comb begin
    cpu_gnt = 1'b0;
    aux_gnt = 1'b0;
    if (!rst) begin
      if (cpu_req && aux_req) begin
        aux_gnt = aux_force;
        cpu_gnt = !aux_force;
      end else begin
        cpu_gnt = cpu_req;
        aux_gnt = aux_req;
      end
    end
  end

  // Idle cycles keep the last address on the ROM to avoid needless output toggling.
  always_comb begin
    rom_addr = last_addr_q;
    owner_d  = OWN_NONE;
    if (cpu_gnt) begin
      rom_addr = cpu_addr;
      owner_d  = OWN_CPU;
    end else if (aux_gnt) begin
      rom_addr = aux_addr;
      owner_d  = OWN_AUX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      last_addr_q <= '0;
    end else begin
      owner_q     <= owner_d;
      last_addr_q <= rom_addr;
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU) && !rst;
  assign aux_rvalid = (owner_q == OWN_AUX) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      if (cpu_rvalid) cpu_rdata_q <= rom_data;
      if (aux_rvalid) aux_rdata_q <= rom_data;
    end
  end

  // The byte is visible in its valid cycle straight from the ROM, then held.
  assign cpu_rdata = cpu_rvalid ? rom_data : cpu_rdata_q;
  assign aux_rdata = aux_rvalid ? rom_data : aux_rdata_q;

endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single synchronous program ROM (1-cycle registered read, 15-bit address, 8-bit data) between two requesters: the 6502 core (instruction/data fetch) and an auxiliary reader (debug dump / loader-verify path). Grants at most one read per cycle, routes each returned byte to its owner with a valid strobe, and bounds auxiliary starvation with an age counter. Sits between the CPU bus decoder's ROM window and the ROM instance.

## Interface
- ADDR_W, 15, ROM address width
- DATA_W, 8, ROM data width
- MAX_WAIT, 4, cycles aux may be refused while CPU contends before aux is forced through (≥1)

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- cpu_req  in  1  CPU requests a ROM read this cycle
- cpu_addr  in  ADDR_W  CPU read address
- cpu_gnt  out  1  CPU request accepted this cycle (combinational)
- cpu_rvalid  out  1  cpu_rdata carries the byte for the request granted last cycle
- cpu_rdata  out  DATA_W  last byte returned to CPU (held)
- aux_req  in  1  aux requests a ROM read
- aux_addr  in  ADDR_W  aux read address
- aux_gnt  out  1  aux request accepted this cycle (combinational)
- aux_rvalid  out  1  aux_rdata valid for request granted last cycle
- aux_rdata  out  DATA_W  last byte returned to aux (held)
- rom_addr  out  ADDR_W  address presented to ROM (combinational from grant)
- rom_data  in  DATA_W  ROM registered output

## Operation
- Requesters hold req and addr stable until gnt; a granted cycle is a completed handshake, requester may change addr next cycle.
- Arbitration per cycle: only one req → it is granted. Both → CPU granted unless aux_age == MAX_WAIT, then aux granted. Neither → no grant.
- rom_addr = granted requester's address; when no grant, rom_addr holds the previously driven value (register last_addr) so ROM output does not toggle needlessly.
- In-flight owner register owner ∈ {OWN_NONE, OWN_CPU, OWN_AUX}, loaded every cycle from the grant decision.
- Response cycle: if owner == OWN_CPU, cpu_rvalid = 1 and cpu_rdata register loads rom_data; likewise for aux. rdata registers otherwise hold.
- aux_age: increments (saturating at MAX_WAIT) each cycle aux_req && !aux_gnt; clears to 0 on aux_gnt or when aux_req is low.
- Back-to-back grants allowed every cycle, to either port; one read in flight per cycle, no queueing.

## Timing
- Reset (rst high at edge): owner = OWN_NONE, aux_age = 0, last_addr = 0, cpu_rdata = aux_rdata = 0; cpu_rvalid = aux_rvalid = 0 in the cycle after. gnt outputs are forced 0 while rst is high.
- Latency: grant in cycle N → rom_data sampled at ROM edge ending N → rvalid in cycle N+1; rdata register updated at edge ending N+1 and stable from N+2 (rdata is combinationally rom_data during the rvalid cycle, then held).
- rst asserted in cycle N+1 after a grant in N: rvalid suppressed, response discarded.
- Simultaneous aux forced grant and CPU req: CPU sees cpu_gnt = 0 (acts as 6502 RDY low) and retries next cycle; CPU is never refused two consecutive contested cycles.
- aux_age width = $clog2(MAX_WAIT+1); no wrap.

## Structure
- Package rom_arb_pkg: owner_e enum (OWN_NONE, OWN_CPU, OWN_AUX), default ADDR_W/DATA_W constants shared with the ROM and bus decoder.
- One sub-module natural: rom_arb_age_counter (saturating counter with clear, parameter MAX). Arbiter, owner register, and return steering stay in top.

## Test plan
- Reset: hold rst 3 cycles with both reqs high → both gnt = 0, rvalid = 0, rdata = 0 throughout and one cycle after release.
- Single CPU read: ROM[0x0010] = 0xA9, cpu_req with addr 0x0010 in cycle N → cpu_gnt in N, cpu_rvalid and cpu_rdata = 0xA9 in N+1, rdata still 0xA9 in N+3, aux_rvalid never set.
- Contention, MAX_WAIT = 4: both reqs held high → CPU granted cycles 0-3, aux granted cycle 4, CPU cycle 5, pattern repeats with period 5; aux_rdata matches aux_addr contents.
- Streaming: aux alone, addresses 0x7FFC..0x7FFF over 4 consecutive cycles → aux_rvalid high 4 consecutive cycles with matching bytes, last_addr = 0x7FFF after.
- Reset mid-flight: CPU granted in N, rst high in N+1 → cpu_rvalid = 0 in N+1, cpu_rdata = 0 after reset.
- Age clear: aux_req drops after 3 refused cycles then reasserts → aux waits full 4 contested cycles again before forced grant.
